// File: rtl/uart_rx_if.sv
// Serial-link bundle between the RS-232 pin, the baud-tick generator and the command decoder.
// Latency: none; wires only.
// Backpressure: none; the receiver strobes results and the consumer must take them.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();

    // Line side and baud generator handshake
    logic                 rs232_rx;
    logic                 clk_bps;
    logic                 bps_start;

    // Result side towards the command decoder
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;

    // The receiver itself
    modport master (
        input  rs232_rx,
        input  clk_bps,
        output bps_start,
        output rx_data,
        output rx_valid,
        output frame_err
    );

    // Everything around the receiver: line driver, baud generator, consumer
    modport slave (
        output rs232_rx,
        output clk_bps,
        input  bps_start,
        input  rx_data,
        input  rx_valid,
        input  frame_err
    );

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receive engine: recovers bytes from rs232_rx using the external mid-bit clk_bps pulses.
// Latency: rx_valid/frame_err assert on the edge after the stop-bit clk_bps; start edge seen 3 clk after the line falls.
// Backpressure: none; each result is a one-cycle strobe and rx_data holds until the next good frame.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.master bus
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               state;
    state_t               state_nxt;

    // Line synchroniser; rx_s2 is the usable line, rx_s3 its one-cycle-old copy
    logic                 rx_s1;
    logic                 rx_s2;
    logic                 rx_s3;
    logic                 fall;

    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_nxt;

    logic [DATA_BITS-1:0] rx_data_q;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_q;
    logic                 rx_valid_nxt;
    logic                 frame_err_q;
    logic                 frame_err_nxt;
    logic                 bps_start_q;
    logic                 bps_start_nxt;

    assign fall = rx_s3 & ~rx_s2;

    assign bus.bps_start = bps_start_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;

    // Bring the asynchronous line into the clk domain; idle-high reset value avoids a false start edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= bus.rs232_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            shift       <= '0;
            bit_cnt     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            bps_start_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            shift       <= shift_nxt;
            bit_cnt     <= bit_cnt_nxt;
            rx_data_q   <= rx_data_nxt;
            rx_valid_q  <= rx_valid_nxt;
            frame_err_q <= frame_err_nxt;
            bps_start_q <= bps_start_nxt;
        end
    end

    // Frame sequencing: sample start, data bits LSB first and stop bit on each clk_bps
    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bit_cnt_nxt   = bit_cnt;
        rx_data_nxt   = rx_data_q;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;

        unique case (state)
            S_IDLE: begin
                // clk_bps is meaningless here: the generator is held cleared
                if (fall) begin
                    state_nxt = S_START;
                end
            end

            S_START: begin
                if (bus.clk_bps) begin
                    if (!rx_s2) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end else begin
                        // Line already back high at mid start bit: a glitch, drop it silently
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (bus.clk_bps) begin
                    shift_nxt   = {rx_s2, shift[DATA_BITS-1:1]};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = S_STOP;
                    end
                end
            end

            S_STOP: begin
                if (bus.clk_bps) begin
                    if (rx_s2) begin
                        rx_data_nxt  = shift;
                        rx_valid_nxt = 1'b1;
                        state_nxt    = S_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // A line stuck low must go high again before another start edge can count
                if (rx_s2) begin
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Generator runs exactly while a frame is in progress; falls with the stop-bit strobe
        bps_start_nxt = (state_nxt == S_START) || (state_nxt == S_DATA) || (state_nxt == S_STOP);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
// Latency: expected strobe at a fixed offset from the start-bit edge given by the bit period.
// Backpressure: none; strobes are consumed by the compare process every cycle.
module tb_uart_rx;

    // Bit period shortened from 5208 clk so the whole run stays short; mid-bit tick at half period
    localparam int BIT  = 40;
    localparam int HALF = BIT / 2;
    // Line falls after edge k: fall seen edge k+2, START edge k+3, first tick HALF later, stop sample 9 bits on
    localparam int LAT  = HALF + 9 * BIT + 4;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         f;
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   bcnt  = 0;
    logic rst_applied = 1'b0;

    ev_t        q[$];
    ev_t        e_cmp;
    int         vcyc[$];
    logic [7:0] last_good = 8'h00;
    int         n_valid = 0;
    int         n_err   = 0;
    int         bps_hi  = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rst_applied <= ~reset;

    // Baud generator: cleared while bps_start is low, ticks mid-bit once per period
    always @(posedge clk) begin
        if (!bus.bps_start) bcnt <= 0;
        else                bcnt <= (bcnt == BIT - 1) ? 0 : bcnt + 1;
    end
    assign bus.clk_bps = bus.bps_start && (bcnt == HALF);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one 8N1 frame; optionally record what the receiver must report for it
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit expect_it);
        ev_t e;
        if (expect_it) begin
            e.err  = !stop_ok;
            e.data = b;
            e.f    = cyc;
            q.push_back(e);
        end
        bus.rs232_rx = 1'b0;
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rs232_rx = b[i];
            hold(BIT);
        end
        bus.rs232_rx = stop_ok;
        hold(BIT);
    endtask

    task automatic glitch(input int g);
        bus.rs232_rx = 1'b0;
        hold(g);
        bus.rs232_rx = 1'b1;
        hold(BIT + HALF);
    endtask

    // Monitor: time spent with the baud generator enabled
    always @(negedge clk) begin
        if (bus.bps_start === 1'b1) bps_hi++;
    end

    // Compare process: every cycle, outputs against the frame-level expectation queue
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_applied) begin
                chk("rst_bps_start", bus.bps_start, 0);
                chk("rst_rx_valid", bus.rx_valid, 0);
                chk("rst_frame_err", bus.frame_err, 0);
                chk("rst_rx_data", bus.rx_data, 0);
                last_good = 8'h00;
                q.delete();
            end else begin
                chk("valid_err_exclusive", bus.rx_valid & bus.frame_err, 0);
                if (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1) begin
                    if (bus.rx_valid === 1'b1) begin
                        n_valid++;
                        vcyc.push_back(cyc);
                    end else begin
                        n_err++;
                    end
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_strobe: valid=%0b err=%0b data=%0h with no frame pending",
                                 bus.rx_valid, bus.frame_err, bus.rx_data);
                    end else begin
                        e_cmp = q.pop_front();
                        chk("strobe_is_err", bus.frame_err, e_cmp.err);
                        chk("strobe_latency", cyc - e_cmp.f, LAT);
                        if (bus.rx_valid === 1'b1) begin
                            chk("rx_data", bus.rx_data, e_cmp.data);
                            last_good = e_cmp.data;
                        end else begin
                            chk("rx_data_after_err", bus.rx_data, last_good);
                        end
                    end
                end else begin
                    chk("rx_data_hold", bus.rx_data, last_good);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, e0, b0, gap;
        logic [7:0] b;
        int r;

        bus.rs232_rx = 1'b1;
        reset        = 1'b0;
        @(posedge clk);
        #1;

        // Reset held from time 0 while the line toggles
        for (int i = 0; i < 40; i++) begin
            bus.rs232_rx = 1'($urandom_range(0, 1));
            hold(1);
        end
        @(negedge clk);
        chk("reset_hold_rx_data", bus.rx_data, 8'h00);
        chk("reset_hold_bps_start", bus.bps_start, 0);
        @(posedge clk);
        #1;
        bus.rs232_rx = 1'b1;
        hold(4);
        reset = 1'b1;
        hold(10);

        // Single frame 0x55
        v0 = n_valid; e0 = n_err;
        send_frame(8'h55, 1'b1, 1'b1);
        hold(BIT);
        chk("f55_rx_data", bus.rx_data, 8'h55);
        chk("f55_valid_count", n_valid - v0, 1);
        chk("f55_err_count", n_err - e0, 0);
        chk("f55_bps_low", bus.bps_start, 0);

        // Back-to-back 0xA3, 0x0F with no idle gap
        v0 = n_valid;
        vcyc.delete();
        send_frame(8'hA3, 1'b1, 1'b1);
        send_frame(8'h0F, 1'b1, 1'b1);
        hold(BIT);
        chk("b2b_valid_count", n_valid - v0, 2);
        gap = (vcyc.size() == 2) ? vcyc[1] - vcyc[0] : -1;
        chk("b2b_gap", gap, 10 * BIT);
        chk("b2b_rx_data", bus.rx_data, 8'h0F);

        // 0x81 with a low stop bit, line held low 3 bits, then released
        v0 = n_valid; e0 = n_err;
        send_frame(8'h81, 1'b0, 1'b1);
        for (int i = 0; i < 3 * BIT; i++) begin
            @(negedge clk);
            chk("break_bps_low", bus.bps_start, 0);
        end
        @(posedge clk);
        #1;
        bus.rs232_rx = 1'b1;
        b0 = bps_hi;
        hold(2 * BIT);
        chk("break_no_restart", bps_hi - b0, 0);
        chk("break_err_count", n_err - e0, 1);
        chk("break_valid_count", n_valid - v0, 0);
        chk("break_rx_data_kept", bus.rx_data, 8'h0F);

        // Short low glitch on an idle line
        v0 = n_valid; e0 = n_err; b0 = bps_hi;
        glitch(HALF / 2);
        chk("glitch_bps_pulsed", (bps_hi - b0) > 0, 1);
        chk("glitch_bps_low", bus.bps_start, 0);
        chk("glitch_no_valid", n_valid - v0, 0);
        chk("glitch_no_err", n_err - e0, 0);

        // Reset for 2 clk in the data phase of 0xFF, then a clean 0x3C
        v0 = n_valid; e0 = n_err;
        fork
            send_frame(8'hFF, 1'b1, 1'b0);
            begin
                hold(4 * BIT);
                reset = 1'b0;
                hold(2);
                reset = 1'b1;
            end
        join
        hold(BIT);
        chk("abort_no_valid", n_valid - v0, 0);
        chk("abort_no_err", n_err - e0, 0);
        chk("abort_rx_data_cleared", bus.rx_data, 8'h00);
        send_frame(8'h3C, 1'b1, 1'b1);
        hold(BIT);
        chk("after_reset_rx_data", bus.rx_data, 8'h3C);
        chk("after_reset_valid_count", n_valid - v0, 1);

        // Random mix of good frames, framing errors and glitches
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 255));
            if (r == 0) begin
                glitch($urandom_range(1, HALF / 2));
            end else if (r == 1) begin
                send_frame(b, 1'b0, 1'b1);
                hold($urandom_range(0, 3) * BIT + $urandom_range(0, HALF));
                bus.rs232_rx = 1'b1;
                hold(BIT);
            end else begin
                send_frame(b, 1'b1, 1'b1);
                hold($urandom_range(0, BIT));
            end
        end

        // Every recorded frame must have been reported
        for (int i = 0; i < 4 * BIT; i++) begin
            if (q.size() == 0) break;
            hold(1);
        end
        chk("queue_drained", q.size(), 0);
        chk("final_bps_low", bus.bps_start, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
